// File: rtl/gpr_wb_arbiter_if.sv
// GPR writeback arbiter bus: two writeback requesters, clear-sweep control
// and the resulting register-file write port.
// Ports: slave = arbiter side (takes requests, drives grants and the GPR write);
//        master = requester/register-file side (the mirror image).
interface gpr_wb_arbiter_if;
  logic        a_req;
  logic [4:0]  a_rd;
  logic [31:0] a_wd;
  logic        a_gnt;
  logic        b_req;
  logic [4:0]  b_rd;
  logic [31:0] b_wd;
  logic        b_gnt;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        gpr_we;
  logic [4:0]  gpr_rd;
  logic [31:0] gpr_wd;

  modport slave (
    input  a_req, a_rd, a_wd, b_req, b_rd, b_wd, clr_start,
    output a_gnt, b_gnt, clr_busy, clr_done, gpr_we, gpr_rd, gpr_wd
  );

  modport master (
    output a_req, a_rd, a_wd, b_req, b_rd, b_wd, clr_start,
    input  a_gnt, b_gnt, clr_busy, clr_done, gpr_we, gpr_rd, gpr_wd
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Purpose: arbitrates ALU (A) and load (B) writebacks onto one GPR write port and runs a register-clear sweep.
// Latency: 1 cycle from an eligible request (or clr_start) to the registered write/grant; all outputs registered.
// Backpressure: a requester holds req/rd/wd until its gnt pulse; a clear sweep stalls both requesters until clr_done.
//
// Ports: clk, rst (async active-low); bus (gpr_wb_arbiter_if.slave): a_*/b_* request/grant,
//        clr_start/clr_busy/clr_done sweep control, gpr_we/gpr_rd/gpr_wd register-file write.
// Build option: GPR_WB_RR_EN defined -> round-robin between simultaneous requesters;
//               undefined -> fixed priority A over B and no last-grant register.
module gpr_wb_arbiter #(
  parameter int NREG      = 32,
  parameter int CLR_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  gpr_wb_arbiter_if.slave       bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [4:0] LP_FIRST = 5'(CLR_FIRST);
  localparam logic [4:0] LP_LAST  = 5'(NREG - 1);

  state_t      r_state, w_state_nxt;
  logic        r_we, w_we_nxt;
  logic [4:0]  r_rd, w_rd_nxt;
  logic [31:0] r_wd, w_wd_nxt;
  logic        r_a_gnt, w_a_gnt_nxt;
  logic        r_b_gnt, w_b_gnt_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  // Index of the clear write currently on the GPR port while in CLEAR;
  // parked at the first index while idle.
  logic [4:0]  r_clr_idx, w_clr_idx_nxt;

  logic        w_a_elig, w_b_elig, w_pick_a;
  logic [4:0]  w_win_rd;
  logic [31:0] w_win_wd;

  // A requester that is being granted this cycle is still showing the write
  // just issued, so it must not be picked again until the next cycle.
  assign w_a_elig = bus.a_req & ~r_a_gnt;
  assign w_b_elig = bus.b_req & ~r_b_gnt;

`ifdef GPR_WB_RR_EN
  // 1 = A won the most recent grant; reset says B so A wins the first tie.
  logic r_last_a, w_last_a_nxt;

  always_comb begin
    if (w_a_elig && w_b_elig) w_pick_a = ~r_last_a;
    else                      w_pick_a = w_a_elig;
  end

  always_comb begin
    w_last_a_nxt = r_last_a;
    if (w_a_gnt_nxt)      w_last_a_nxt = 1'b1;
    else if (w_b_gnt_nxt) w_last_a_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_last_a <= 1'b0;
    else      r_last_a <= w_last_a_nxt;
  end
`else
  // Fixed priority: A whenever it is eligible.
  assign w_pick_a = w_a_elig;
`endif

  assign w_win_rd = w_pick_a ? bus.a_rd : bus.b_rd;
  assign w_win_wd = w_pick_a ? bus.a_wd : bus.b_wd;

  always_comb begin
    w_state_nxt   = r_state;
    w_we_nxt      = 1'b0;
    w_rd_nxt      = r_rd;
    w_wd_nxt      = r_wd;
    w_a_gnt_nxt   = 1'b0;
    w_b_gnt_nxt   = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      S_CLEAR: begin
        // clr_start is ignored here; the sweep stops at the last index
        // instead of letting the 5-bit counter wrap.
        if (r_clr_idx == LP_LAST) begin
          w_state_nxt   = S_IDLE;
          w_done_nxt    = 1'b1;
          w_clr_idx_nxt = LP_FIRST;
        end else begin
          w_clr_idx_nxt = r_clr_idx + 5'd1;
          w_we_nxt      = 1'b1;
          w_rd_nxt      = r_clr_idx + 5'd1;
          w_wd_nxt      = 32'd0;
          w_busy_nxt    = 1'b1;
        end
      end
      default: begin
        if (bus.clr_start) begin
          // First clear write goes out on the same edge that enters CLEAR.
          w_state_nxt = S_CLEAR;
          w_we_nxt    = 1'b1;
          w_rd_nxt    = r_clr_idx;
          w_wd_nxt    = 32'd0;
          w_busy_nxt  = 1'b1;
        end else if (w_a_elig || w_b_elig) begin
          w_a_gnt_nxt = w_pick_a;
          w_b_gnt_nxt = ~w_pick_a;
          // r0 is hardwired zero: the winner is acknowledged but nothing is written.
          w_we_nxt    = (w_win_rd != 5'd0);
          w_rd_nxt    = w_win_rd;
          w_wd_nxt    = w_win_wd;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_rd      <= 5'd0;
      r_wd      <= 32'd0;
      r_a_gnt   <= 1'b0;
      r_b_gnt   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clr_idx <= LP_FIRST;
    end else begin
      r_state   <= w_state_nxt;
      r_we      <= w_we_nxt;
      r_rd      <= w_rd_nxt;
      r_wd      <= w_wd_nxt;
      r_a_gnt   <= w_a_gnt_nxt;
      r_b_gnt   <= w_b_gnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  assign bus.a_gnt    = r_a_gnt;
  assign bus.b_gnt    = r_b_gnt;
  assign bus.clr_busy = r_busy;
  assign bus.clr_done = r_done;
  assign bus.gpr_we   = r_we;
  assign bus.gpr_rd   = r_rd;
  assign bus.gpr_wd   = r_wd;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios with literal expectations,
// then randomized requests/clears, all compared each cycle to a queue-based model.
module tb_gpr_wb_arbiter;
  localparam int NREG      = 32;
  localparam int CLR_FIRST = 1;
`ifdef GPR_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gpr_wb_arbiter_if bus_if ();

  gpr_wb_arbiter #(.NREG(NREG), .CLR_FIRST(CLR_FIRST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        exp_we = 0, exp_a_gnt = 0, exp_b_gnt = 0, exp_busy = 0, exp_done = 0;
  logic [4:0]  exp_rd = 0;
  logic [31:0] exp_wd = 0;
  int          sweep_q[$];
  bit          sweeping = 0;
  bit          last_was_a = 0;
  bit          m_a_ok, m_b_ok, m_pick_a;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      exp_we = 0; exp_a_gnt = 0; exp_b_gnt = 0; exp_busy = 0; exp_done = 0;
      exp_rd = 0; exp_wd = 0;
      sweep_q.delete();
      sweeping = 0;
      last_was_a = 0;
    end else begin
      m_a_ok = bus_if.a_req && !exp_a_gnt;
      m_b_ok = bus_if.b_req && !exp_b_gnt;
      exp_a_gnt = 0; exp_b_gnt = 0; exp_we = 0; exp_done = 0; exp_busy = 0;
      if (sweeping) begin
        if (sweep_q.size() > 0) begin
          exp_rd = 5'(sweep_q.pop_front());
          exp_wd = 0; exp_we = 1; exp_busy = 1;
        end else begin
          sweeping = 0;
          exp_done = 1;
        end
      end else if (bus_if.clr_start) begin
        for (int i = CLR_FIRST; i < NREG; i++) sweep_q.push_back(i);
        sweeping = 1;
        exp_rd = 5'(sweep_q.pop_front());
        exp_wd = 0; exp_we = 1; exp_busy = 1;
      end else if (m_a_ok || m_b_ok) begin
        if (m_a_ok && m_b_ok) m_pick_a = RR ? !last_was_a : 1'b1;
        else                  m_pick_a = m_a_ok;
        last_was_a = m_pick_a;
        exp_a_gnt = m_pick_a;
        exp_b_gnt = !m_pick_a;
        exp_rd = m_pick_a ? bus_if.a_rd : bus_if.b_rd;
        exp_wd = m_pick_a ? bus_if.a_wd : bus_if.b_wd;
        exp_we = (exp_rd != 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("ctrl{we,agnt,bgnt,busy,done}",
            32'({bus_if.gpr_we, bus_if.a_gnt, bus_if.b_gnt, bus_if.clr_busy, bus_if.clr_done}),
            32'({exp_we, exp_a_gnt, exp_b_gnt, exp_busy, exp_done}));
      if (exp_we) begin
        check("gpr_rd", 32'(bus_if.gpr_rd), 32'(exp_rd));
        check("gpr_wd", bus_if.gpr_wd, exp_wd);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit found;

  initial begin
    bus_if.a_req = 0; bus_if.a_rd = 0; bus_if.a_wd = 0;
    bus_if.b_req = 0; bus_if.b_rd = 0; bus_if.b_wd = 0;
    bus_if.clr_start = 0;

    repeat (3) @(negedge clk);
    // reset state
    check("rst_we",   32'(bus_if.gpr_we), 0);
    check("rst_rd",   32'(bus_if.gpr_rd), 0);
    check("rst_wd",   bus_if.gpr_wd, 0);
    check("rst_gnt",  32'({bus_if.a_gnt, bus_if.b_gnt}), 0);
    check("rst_clr",  32'({bus_if.clr_busy, bus_if.clr_done}), 0);
    rst = 1;
    check_en = 1;

    // single A write, latency 1
    bus_if.a_req = 1; bus_if.a_rd = 5; bus_if.a_wd = 32'h1234ABCD;
    @(negedge clk);
    check("a1_we",  32'(bus_if.gpr_we), 1);
    check("a1_rd",  32'(bus_if.gpr_rd), 5);
    check("a1_wd",  bus_if.gpr_wd, 32'h1234ABCD);
    check("a1_gnt", 32'({bus_if.a_gnt, bus_if.b_gnt}), 32'b10);
    check("model_a1_rd", 32'(exp_rd), 5);
    bus_if.a_req = 0;
    @(negedge clk);
    check("idle_gnt", 32'({bus_if.gpr_we, bus_if.a_gnt, bus_if.b_gnt}), 0);

    // B write to r0: granted, no write enable
    bus_if.b_req = 1; bus_if.b_rd = 0; bus_if.b_wd = 32'hFFFFFFFF;
    @(negedge clk);
    check("b0_gnt", 32'({bus_if.a_gnt, bus_if.b_gnt}), 32'b01);
    check("b0_we",  32'(bus_if.gpr_we), 0);
    check("model_b0_gnt", 32'(exp_b_gnt), 1);
    bus_if.b_req = 0;
    @(negedge clk);

    // both requesting: A,B,A,B then A
    bus_if.a_req = 1; bus_if.a_rd = 3; bus_if.a_wd = 32'hA0A0A0A0;
    bus_if.b_req = 1; bus_if.b_rd = 4; bus_if.b_wd = 32'hB0B0B0B0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("alt_gnt", 32'({bus_if.a_gnt, bus_if.b_gnt}), (k % 2 == 0) ? 32'b10 : 32'b01);
      check("alt_rd",  32'(bus_if.gpr_rd), (k % 2 == 0) ? 32'd3 : 32'd4);
    end
    bus_if.b_req = 0;
    @(negedge clk);
    check("alt_last", 32'({bus_if.a_gnt, bus_if.b_gnt}), 32'b10);
    bus_if.a_req = 0;
    @(negedge clk);

    // clear sweep with A pending
    bus_if.a_req = 1; bus_if.a_rd = 7; bus_if.a_wd = 32'h00C0FFEE;
    bus_if.clr_start = 1;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      bus_if.clr_start = 0;
      check("clr_we",   32'(bus_if.gpr_we), 1);
      check("clr_rd",   32'(bus_if.gpr_rd), 32'(i));
      check("clr_wd",   bus_if.gpr_wd, 0);
      check("clr_agnt", 32'(bus_if.a_gnt), 0);
      check("clr_busy", 32'(bus_if.clr_busy), 1);
    end
    @(negedge clk);
    check("clr_done", 32'({bus_if.clr_done, bus_if.clr_busy, bus_if.gpr_we, bus_if.a_gnt}), 32'b1000);
    @(negedge clk);
    check("post_clr_gnt", 32'({bus_if.a_gnt, bus_if.gpr_we, bus_if.clr_done}), 32'b110);
    check("post_clr_rd",  32'(bus_if.gpr_rd), 7);
    bus_if.a_req = 0;
    @(negedge clk);

    // reset in the middle of a sweep
    bus_if.clr_start = 1;
    @(negedge clk);
    bus_if.clr_start = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus_if.gpr_we && bus_if.gpr_rd == 5'd10) found = 1;
      else @(negedge clk);
    end
    check("wait_rd10", 32'(found), 1);
    #3 rst = 0;
    #1;
    check("mid_rst_outs",
          32'({bus_if.gpr_we, bus_if.a_gnt, bus_if.b_gnt, bus_if.clr_busy, bus_if.clr_done}), 0);
    check("mid_rst_rd", 32'(bus_if.gpr_rd), 0);
    check("mid_rst_wd", bus_if.gpr_wd, 0);
    repeat (2) @(negedge clk);
    #3 rst = 1;
    @(negedge clk);
    check("no_done_after_rst", 32'(bus_if.clr_done), 0);
    bus_if.a_req = 1; bus_if.a_rd = 9; bus_if.a_wd = 32'h99990000;
    @(negedge clk);
    check("rst_then_gnt", 32'({bus_if.a_gnt, bus_if.gpr_we, bus_if.clr_done}), 32'b110);
    check("rst_then_rd",  32'(bus_if.gpr_rd), 9);
    bus_if.a_req = 0;
    @(negedge clk);

    // randomized traffic; requesters obey hold-until-grant
    for (int c = 0; c < 3000; c++) begin
      if (!bus_if.a_req || bus_if.a_gnt) begin
        bus_if.a_req = ($urandom_range(0, 3) != 0);
        bus_if.a_rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus_if.a_wd  = $urandom;
      end
      if (!bus_if.b_req || bus_if.b_gnt) begin
        bus_if.b_req = ($urandom_range(0, 2) != 0);
        bus_if.b_rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus_if.b_wd  = $urandom;
      end
      bus_if.clr_start = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    bus_if.a_req = 0; bus_if.b_req = 0; bus_if.clr_start = 0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREG, default 32, giving the number of GPR entries swept by a clear.
REQ-002 The block SHALL have parameter CLR_FIRST, default 1, giving the first index swept by a clear (r0 is never written).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset:
  clk        in   1   rising-edge clock
  rst        in   1   asynchronous active-low reset
  a_req      in   1   requester A (ALU writeback) write request
  a_rd       in   5   requester A destination index
  a_wd       in   32  requester A write data
  a_gnt      out  1   one-cycle pulse: A's write issued
  b_req      in   1   requester B (load writeback) write request
  b_rd       in   5   requester B destination index
  b_wd       in   32  requester B write data
  b_gnt      out  1   one-cycle pulse: B's write issued
  clr_start  in   1   start a register-clear sweep
  clr_busy   out  1   sweep in progress
  clr_done   out  1   one-cycle pulse: sweep finished
  gpr_we     out  1   GPR write enable
  gpr_rd     out  5   GPR write index
  gpr_wd     out  32  GPR write data

Function
REQ-004 The FSM SHALL have exactly two states, IDLE and CLEAR.
REQ-005 All outputs SHALL be registered; no input-to-output combinational path.
REQ-006 Requester protocol: req/rd/wd held stable from assertion until the cycle gnt is high; req may stay high in the gnt cycle to present the next write.
REQ-007 A requester whose gnt is high in cycle N SHALL NOT be eligible in cycle N.
REQ-008 In IDLE with clr_start low, one eligible requester SHALL be chosen per cycle; at the next edge gpr_we=1, gpr_rd/gpr_wd=winner's rd/wd, and the winner's gnt=1 for exactly one cycle (latency 1).
REQ-009 A winner with rd==0 SHALL still receive gnt, but gpr_we SHALL be 0 that cycle.
REQ-010 Cycles with no eligible requester SHALL have gpr_we=0, a_gnt=0, b_gnt=0; gpr_rd/gpr_wd hold their last values.
REQ-011 a_gnt and b_gnt SHALL never be high in the same cycle.
REQ-012 clr_start high in IDLE SHALL take priority over requests and move to CLEAR at the next edge; pending requests wait, with no grants.
REQ-013 In CLEAR, one write per cycle SHALL be issued (gpr_we=1, gpr_wd=0) with gpr_rd stepping CLR_FIRST..NREG-1, i.e. NREG-CLR_FIRST cycles; clr_busy=1 throughout.
REQ-014 The cycle after the last clear write, clr_done SHALL be 1 for one cycle, clr_busy=0, and the FSM SHALL be IDLE; arbitration resumes in that cycle's evaluation.
REQ-015 clr_start in CLEAR SHALL be ignored.
REQ-016 The 5-bit clear index SHALL not wrap; the sweep ends at NREG-1.

Reset
REQ-017 rst low SHALL force, asynchronously: state=IDLE, gpr_we=0, gpr_rd=0, gpr_wd=0, a_gnt=0, b_gnt=0, clr_busy=0, clr_done=0, clear index=CLR_FIRST, last-grant=B.
REQ-018 Reset mid-sweep SHALL abandon the sweep with no clr_done; the first edge after rst rises SHALL evaluate as IDLE.

Configuration
REQ-019 With GPR_WB_RR_EN defined, simultaneous eligible requests SHALL be granted round-robin: the requester not granted last wins.
REQ-020 Without GPR_WB_RR_EN, simultaneous eligible requests SHALL use fixed priority, A over B; the last-grant register is not built.

Verification
REQ-021 After reset, a_req=1, a_rd=5, a_wd=0x1234ABCD for one cycle -> next cycle gpr_we=1, gpr_rd=5, gpr_wd=0x1234ABCD, a_gnt=1.
REQ-022 a_req and b_req held high together (a_rd=3, b_rd=4) with RR -> grants A,B,A,B on consecutive cycles; without RR -> A every other cycle, B in the gaps left by REQ-007.
REQ-023 b_req=1, b_rd=0, b_wd=0xFFFFFFFF -> b_gnt=1, gpr_we=0.
REQ-024 clr_start with a_req high (defaults) -> 31 cycles of gpr_we=1, gpr_wd=0, gpr_rd=1..31, no a_gnt; then clr_done=1; A is granted in the following cycle.
REQ-025 rst low during the clear write to gpr_rd=10 -> all outputs 0 immediately; no clr_done; a request after rst rises is granted with latency 1.
